zap_mul_arbiter: RTL

Arbitrates between NREQ requesters (ALU issue, DSP coprocessor port, …) for one shared iterative multiplier core (4-state 17x17 FSM multiplier with combinational `busy`). Latches the winning request's operands, holds them stable on the core's op/operand inputs, and sequences 64-bit operations as a low pass followed by a back-to-back high pass. Returns a tagged result on a shared response bus. Sits between the issue/coprocessor front ends and the multiplier core in the shifter stage.

---
 rtl/zap_mul_arbiter_if.sv | 41 ++++
 rtl/zap_mul_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/zap_mul_arbiter_if.sv
// zap_mul_arbiter_if
//   Requester-side bus of the shared multiplier arbiter: per-requester
//   request handshake and operands (flattened, requester k in slice k) plus
//   the shared tagged response.
//   master : requester front ends (drive requests, receive grant/response)
//   slave  : zap_mul_arbiter
//   req_valid/req_ready : NREQ     request valid / one-hot grant
//   req_op              : NREQ*OPW opcode, low-pass code (bit0 = 0)
//   req_long            : NREQ     64-bit result (low then high pass)
//   req_rm/rs/rn/rh     : NREQ*32  operands
//   rsp_valid           : NREQ     one-hot response strobe
//   rsp_lo/rsp_hi       : 32       result words (hi = 0 for short ops)
//   rsp_sat/rsp_z       : 1        saturation, zero flag of full result
interface zap_mul_arbiter_if #(
  parameter int NREQ = 2,
  parameter int OPW  = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ-1:0]      req_long;
  logic [NREQ*32-1:0]   req_rm;
  logic [NREQ*32-1:0]   req_rs;
  logic [NREQ*32-1:0]   req_rn;
  logic [NREQ*32-1:0]   req_rh;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_lo;
  logic [31:0]          rsp_hi;
  logic                 rsp_sat;
  logic                 rsp_z;

  modport master (
    output req_valid, req_op, req_long, req_rm, req_rs, req_rn, req_rh,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_sat, rsp_z
  );

  modport slave (
    input  req_valid, req_op, req_long, req_rm, req_rs, req_rn, req_rh,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_sat, rsp_z
  );
endinterface

// File: rtl/zap_mul_arbiter.sv
// zap_mul_arbiter
//   Arbitrates NREQ requesters onto one iterative multiplier core. The
//   winner's operands are latched and held on the core inputs; 64-bit
//   operations run a low pass then an immediately following high pass.
//   Completion of a pass is the first cycle after its issue cycle with
//   i_mul_busy low, so no core latency is assumed.
//   Build option: ZAP_MUL_ARBITER_RR_EN selects round-robin arbitration
//   (pointer moves to winner+1 on each handshake); undefined gives fixed
//   priority with the lowest index winning.
//   Ports:
//     i_clk, i_reset   clock, synchronous active-high reset
//     i_flush          abort in-flight op, drop pending response
//     i_stall          freeze state, latches and outputs
//     bus              requester bus (zap_mul_arbiter_if.slave)
//     o_mul_op/rm/rs/rn/rh  op and operands to the core
//     i_mul_busy/sat/nozero/rd  core status and result
module zap_mul_arbiter #(
  parameter int             NREQ   = 2,
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] NOP_OP = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_stall,
  zap_mul_arbiter_if.slave     bus,
  output logic [OPW-1:0]       o_mul_op,
  output logic [31:0]          o_mul_rm,
  output logic [31:0]          o_mul_rs,
  output logic [31:0]          o_mul_rn,
  output logic [31:0]          o_mul_rh,
  input  logic                 i_mul_busy,
  input  logic                 i_mul_sat,
  input  logic                 i_mul_nozero,
  input  logic [31:0]          i_mul_rd
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RSP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IDXW-1:0] w_win;
  logic            w_any;
  logic            w_can_grant;
  logic            w_hs;
  logic            w_in_pass;
  logic            w_done;

  logic [OPW-1:0]  r_op;
  logic            r_long;
  logic [31:0]     r_rm;
  logic [31:0]     r_rs;
  logic [31:0]     r_rn;
  logic [31:0]     r_rh;
  logic [IDXW-1:0] r_idx;
  logic            r_issued;

  logic [31:0]     r_lo;
  logic            r_sat;
  logic            r_nz_lo;

  logic [31:0]     r_rsp_lo;
  logic [31:0]     r_rsp_hi;
  logic            r_rsp_sat;
  logic            r_rsp_z;

  // Pass parity is forced from state, so the latched op bit0 is never used;
  // the core's own nonzero flag is superseded by the flag derived from rd
  // across both passes.
  logic            w_unused;
  assign w_unused = ^{i_mul_nozero, r_op[0]};

`ifdef ZAP_MUL_ARBITER_RR_EN
  logic [IDXW-1:0] r_ptr;

  // Search starts at the pointer and wraps, first valid wins.
  always_comb begin
    int k;
    k     = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(r_ptr) + i) % NREQ;
      if (!w_any && bus.req_valid[k]) begin
        w_any = 1'b1;
        w_win = IDXW'(k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_ptr <= '0;
    else if (w_hs)
      r_ptr <= (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
  end
`else
  // Fixed priority: scan downward so the lowest valid index is kept.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_any = 1'b1;
        w_win = IDXW'(i);
      end
    end
  end
`endif

  // Grant only when a handshake can actually be accepted this cycle, so a
  // requester never sees ready for a transfer that flush/stall/reset drops.
  assign w_can_grant = (r_state == S_IDLE) && !i_reset && !i_flush && !i_stall;

  always_comb begin
    bus.req_ready = '0;
    if (w_can_grant && w_any)
      bus.req_ready[w_win] = 1'b1;
  end

  assign w_hs      = |(bus.req_valid & bus.req_ready);
  assign w_in_pass = (r_state == S_LO) || (r_state == S_HI);
  // The issue cycle's busy value belongs to the previous core activity.
  assign w_done    = w_in_pass && r_issued && !i_mul_busy && !i_stall && !i_flush;

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else if (!i_stall) begin
      case (r_state)
        S_IDLE:  if (w_hs)   w_state_nxt = S_LO;
        S_LO:    if (w_done) w_state_nxt = r_long ? S_HI : S_RSP;
        S_HI:    if (w_done) w_state_nxt = S_RSP;
        S_RSP:               w_state_nxt = S_IDLE;
        default:             w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Set once the issue cycle of the current pass has passed; cleared on
  // every state change so LO->HI starts a fresh issue cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush)
      r_issued <= 1'b0;
    else if (!i_stall)
      r_issued <= w_in_pass && (w_state_nxt == r_state);
  end

  always_ff @(posedge i_clk) begin
    if (w_hs) begin
      r_op   <= bus.req_op[int'(w_win)*OPW +: OPW];
      r_long <= bus.req_long[w_win];
      r_rm   <= bus.req_rm[int'(w_win)*32 +: 32];
      r_rs   <= bus.req_rs[int'(w_win)*32 +: 32];
      r_rn   <= bus.req_rn[int'(w_win)*32 +: 32];
      r_rh   <= bus.req_rh[int'(w_win)*32 +: 32];
      r_idx  <= w_win;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_done && (r_state == S_LO)) begin
      r_lo    <= i_mul_rd;
      r_sat   <= i_mul_sat;
      r_nz_lo <= |i_mul_rd;
    end
  end

  // Response fields load on the final pass completion so they are valid in
  // the RSP cycle and hold until the next response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rsp_lo  <= '0;
      r_rsp_hi  <= '0;
      r_rsp_sat <= 1'b0;
      r_rsp_z   <= 1'b0;
    end else if (w_done && (r_state == S_LO) && !r_long) begin
      r_rsp_lo  <= i_mul_rd;
      r_rsp_hi  <= '0;
      r_rsp_sat <= i_mul_sat;
      r_rsp_z   <= ~|i_mul_rd;
    end else if (w_done && (r_state == S_HI)) begin
      r_rsp_lo  <= r_lo;
      r_rsp_hi  <= i_mul_rd;
      r_rsp_sat <= r_sat | i_mul_sat;
      r_rsp_z   <= !(r_nz_lo || (|i_mul_rd));
    end
  end

  assign bus.rsp_lo  = r_rsp_lo;
  assign bus.rsp_hi  = r_rsp_hi;
  assign bus.rsp_sat = r_rsp_sat;
  assign bus.rsp_z   = r_rsp_z;

  always_comb begin
    bus.rsp_valid = '0;
    if (r_state == S_RSP)
      bus.rsp_valid[r_idx] = 1'b1;
  end

  always_comb begin
    o_mul_op = NOP_OP;
    o_mul_rm = '0;
    o_mul_rs = '0;
    o_mul_rn = '0;
    o_mul_rh = '0;
    if (w_in_pass) begin
      o_mul_op = {r_op[OPW-1:1], (r_state == S_HI)};
      o_mul_rm = r_rm;
      o_mul_rs = r_rs;
      o_mul_rn = r_rn;
      o_mul_rh = r_rh;
    end
  end

endmodule
